// File: rtl/sha_loader_pkg.sv
// Shared types, constants and block-padding helper for the SHA-256 message loader.
package sha_loader_pkg;

    localparam int MAX_MSG_BYTES   = 55;
    localparam int BLOCK_BYTES     = 64;
    localparam int DIGEST_BYTES    = 32;
    localparam int LEN_FIELD_BYTES = 8;
    localparam logic [7:0] PAD_BYTE = 8'h80;

    typedef logic [5:0] cnt_t;
    localparam cnt_t MAX_CNT = cnt_t'(MAX_MSG_BYTES);

    // Index 0 holds the first message byte; block index 63 lands on [511:504].
    typedef logic [MAX_MSG_BYTES-1:0][7:0] msg_buf_t;
    typedef logic [BLOCK_BYTES-1:0][7:0]   block_t;

    typedef enum logic [2:0] {
        LOAD,
        PAD,
        CRST,
        WAIT,
        SEND,
        ERR
    } state_t;

    function automatic block_t pad_block(input msg_buf_t buffer, input cnt_t len);
        block_t blk;
        blk = '0;
        for (int i = 0; i < MAX_MSG_BYTES; i++) begin
            if (i < int'(len)) begin
                blk[BLOCK_BYTES-1-i] = buffer[i];
            end
        end
        blk[cnt_t'(BLOCK_BYTES-1) - len] = PAD_BYTE;
        blk[LEN_FIELD_BYTES-1:0] = 64'({len, 3'b000});
        return blk;
    endfunction

endpackage

// File: rtl/sha_digest_ser.sv
// Loads a 256-bit digest and emits it MSB-first as a valid/ready byte stream.
module sha_digest_ser
    import sha_loader_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      load,
    input  logic [DIGEST_BYTES*8-1:0] digest,
    output logic [7:0]                out_data,
    output logic                      out_valid,
    output logic                      out_last,
    input  logic                      out_ready
);
    logic [DIGEST_BYTES*8-1:0] shreg;
    logic [4:0]                idx;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shreg     <= '0;
            idx       <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end else if (load) begin
            shreg     <= digest;
            idx       <= '0;
            out_valid <= 1'b1;
            out_last  <= 1'b0;
        end else if (out_valid && out_ready) begin
            // Shifting in zeros leaves out_data at 0 once the last byte is gone.
            shreg    <= {shreg[DIGEST_BYTES*8-9:0], 8'h00};
            idx      <= idx + 5'd1;
            out_last <= (idx == 5'(DIGEST_BYTES - 2));
            if (out_last) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end
        end
    end

    assign out_data = shreg[DIGEST_BYTES*8-1 -: 8];

endmodule

// File: rtl/sha_msg_loader.sv
// Collects a 1-55 byte message, pads it into one SHA-256 block, runs the core
// handshake and streams the digest back out.
//
//   state | meaning
//   LOAD  | accepting message bytes
//   PAD   | building the padded block
//   CRST  | core_rst pulse, clears stale hash_done
//   WAIT  | sha_start held, waiting for hash_done or timeout
//   SEND  | digest bytes streaming out
//   ERR   | one-cycle err pulse after overflow or timeout
module sha_msg_loader
    import sha_loader_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [7:0]   in_data,
    input  logic         in_valid,
    input  logic         in_last,
    output logic         in_ready,
    output logic [7:0]   out_data,
    output logic         out_valid,
    output logic         out_last,
    input  logic         out_ready,
    output logic [511:0] blk_data,
    output logic         core_rst,
    output logic         sha_start,
    input  logic         hash_done,
    input  logic [255:0] signature,
    output logic         err
);
    localparam int TIMER_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);

    state_t             state;
    cnt_t               cnt;
    msg_buf_t           msg_buf;
    logic               ovf;
    logic [TIMER_W-1:0] timer;
    logic               ser_load;

    assign ser_load = (state == WAIT) && hash_done;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= LOAD;
            cnt       <= '0;
            msg_buf   <= '0;
            ovf       <= 1'b0;
            timer     <= '0;
            in_ready  <= 1'b0;
            core_rst  <= 1'b0;
            sha_start <= 1'b0;
            err       <= 1'b0;
            blk_data  <= '0;
        end else begin
            core_rst <= 1'b0;
            err      <= 1'b0;
            case (state)
                LOAD: begin
                    in_ready <= 1'b1;
                    if (in_valid && in_ready) begin
                        if (cnt == MAX_CNT) begin
                            ovf <= 1'b1;
                        end else begin
                            msg_buf[cnt] <= in_data;
                            cnt          <= cnt + cnt_t'(1);
                        end
                        if (in_last) begin
                            in_ready <= 1'b0;
                            if (ovf || cnt == MAX_CNT) begin
                                err   <= 1'b1;
                                state <= ERR;
                            end else begin
                                state <= PAD;
                            end
                        end
                    end
                end
                PAD: begin
                    blk_data <= pad_block(msg_buf, cnt);
                    core_rst <= 1'b1;
                    state    <= CRST;
                end
                CRST: begin
                    sha_start <= 1'b1;
                    timer     <= '0;
                    state     <= WAIT;
                end
                WAIT: begin
                    // hash_done takes priority over a timeout landing on the same cycle.
                    if (hash_done) begin
                        sha_start <= 1'b0;
                        state     <= SEND;
                    end else if (timer == TIMER_LAST) begin
                        sha_start <= 1'b0;
                        err       <= 1'b1;
                        state     <= ERR;
                    end else begin
                        timer <= timer + TIMER_W'(1);
                    end
                end
                SEND: begin
                    if (out_valid && out_ready && out_last) begin
                        cnt      <= '0;
                        in_ready <= 1'b1;
                        state    <= LOAD;
                    end
                end
                ERR: begin
                    sha_start <= 1'b0;
                    cnt       <= '0;
                    ovf       <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= LOAD;
                end
                default: begin
                    state <= LOAD;
                end
            endcase
        end
    end

    sha_digest_ser u_ser (
        .clk       (clk),
        .rst       (rst),
        .load      (ser_load),
        .digest    (signature),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_last  (out_last),
        .out_ready (out_ready)
    );

endmodule

// File: tb/tb_sha_msg_loader.sv
// Directed and randomized checks of sha_msg_loader against a stub SHA core and a padding model.
module tb_sha_msg_loader;
    localparam int TIMEOUT = 1024;
    localparam logic [255:0] ABC_DIGEST =
        256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;

    logic         clk = 1'b0;
    logic         rst;
    logic [7:0]   in_data;
    logic         in_valid;
    logic         in_last;
    logic         in_ready;
    logic [7:0]   out_data;
    logic         out_valid;
    logic         out_last;
    logic         out_ready;
    logic [511:0] blk_data;
    logic         core_rst;
    logic         sha_start;
    logic         hash_done = 1'b0;
    logic [255:0] signature = '0;
    logic         err;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    // stub core controls
    logic         stub_en    = 1'b1;
    int           stub_delay = 3;
    logic [255:0] stub_sig   = '0;
    int           busy       = 0;

    // monitor state
    logic [7:0] rx_q[$];
    logic       last_q[$];
    int crst_cnt, sha_rise, ov_cnt, err_cnt;
    int t_last, t_crst, t_start, t_hd, t_ov, t_err;
    logic sha_prev = 1'b0;

    sha_msg_loader #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_last  (out_last),
        .out_ready (out_ready),
        .blk_data  (blk_data),
        .core_rst  (core_rst),
        .sha_start (sha_start),
        .hash_done (hash_done),
        .signature (signature),
        .err       (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (core_rst) begin
            hash_done <= 1'b0;
            busy      <= 0;
        end else if (stub_en && sha_start && !hash_done) begin
            if (busy >= stub_delay) begin
                hash_done <= 1'b1;
                signature <= stub_sig;
            end else begin
                busy <= busy + 1;
            end
        end
    end

    always @(negedge clk) begin
        if (in_valid && in_ready && in_last) t_last = cyc;
        if (core_rst) begin crst_cnt++; t_crst = cyc; end
        if (sha_start && !sha_prev) begin sha_rise++; t_start = cyc; end
        sha_prev = sha_start;
        if (sha_start && hash_done && t_hd < 0) t_hd = cyc;
        if (out_valid) begin ov_cnt++; if (t_ov < 0) t_ov = cyc; end
        if (out_valid && out_ready) begin
            rx_q.push_back(out_data);
            last_q.push_back(out_last);
        end
        if (err) begin err_cnt++; if (t_err < 0) t_err = cyc; end
    end

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic clear_mon();
        rx_q.delete();
        last_q.delete();
        crst_cnt = 0; sha_rise = 0; ov_cnt = 0; err_cnt = 0;
        t_last = -1; t_crst = -1; t_start = -1; t_hd = -1; t_ov = -1; t_err = -1;
    endtask

    // Padded block derived directly from the SHA-256 padding rule.
    function automatic logic [511:0] ref_block(input logic [7:0] m[$]);
        logic [7:0]   b[64];
        logic [63:0]  bits;
        logic [511:0] r;
        foreach (b[i]) b[i] = 8'h00;
        foreach (m[i]) b[i] = m[i];
        b[m.size()] = 8'h80;
        bits = 64'(m.size()) * 64'd8;
        for (int k = 0; k < 8; k++) b[63-k] = bits[8*k +: 8];
        r = '0;
        foreach (b[i]) r = {r[503:0], b[i]};
        return r;
    endfunction

    function automatic logic [255:0] rand_sig();
        logic [255:0] s = '0;
        for (int k = 0; k < 8; k++) s = {s[223:0], 32'($urandom())};
        return s;
    endfunction

    task automatic send_msg(input logic [7:0] m[$]);
        int w;
        for (int i = 0; i < m.size(); i++) begin
            if ($urandom_range(0, 3) == 0) begin
                in_valid = 1'b0;
                in_last  = 1'b0;
                repeat ($urandom_range(1, 2)) @(posedge clk);
                #1;
            end
            in_data  = m[i];
            in_valid = 1'b1;
            in_last  = (i == m.size() - 1);
            w = 0;
            @(negedge clk);
            while (!in_ready && w < 100) begin @(negedge clk); w++; end
            if (!in_ready) begin
                chk("in_ready_wait", 512'(in_ready), 512'd1);
                in_valid = 1'b0;
                in_last  = 1'b0;
                return;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_rx();
        int w = 0;
        while (rx_q.size() < 32 && w < 3000) begin @(negedge clk); w++; end
        repeat (3) @(negedge clk);
    endtask

    task automatic run_msg(input string tag, input logic [7:0] m[$], input logic [255:0] sig,
                           input bit bp);
        logic [255:0] got;
        logic [31:0]  lf;
        int w;
        stub_sig   = sig;
        stub_delay = $urandom_range(0, 6);
        clear_mon();
        send_msg(m);
        if (bp) begin
            w = 0;
            while (!(out_valid && rx_q.size() == 3) && w < 2000) begin @(posedge clk); #1; w++; end
            out_ready = 1'b0;
            for (int k = 0; k < 5; k++) begin
                @(negedge clk);
                chk({tag, "_hold"}, 512'(out_data), 512'(sig[255-24 -: 8]));
            end
            @(posedge clk); #1;
            out_ready = 1'b1;
        end
        wait_rx();
        got = '0;
        lf  = '0;
        foreach (rx_q[i]) got = {got[247:0], rx_q[i]};
        foreach (last_q[i]) lf = {lf[30:0], last_q[i]};
        chk({tag, "_nbytes"}, 512'(rx_q.size()), 512'd32);
        chk({tag, "_digest"}, 512'(got), 512'(sig));
        chk({tag, "_last"}, 512'(lf), 512'd1);
        chk({tag, "_blk"}, blk_data, ref_block(m));
        chk({tag, "_crst"}, 512'(crst_cnt), 512'd1);
        chk({tag, "_start"}, 512'(sha_rise), 512'd1);
    endtask

    initial begin
        logic [7:0] abc[$];
        logic [7:0] m[$];
        int w;
        abc = '{8'h61, 8'h62, 8'h63};
        rst = 1'b0; in_data = '0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
        clear_mon();

        // reset state
        #3;
        chk("rst_ctl", 512'({in_ready, out_valid, out_last, core_rst, sha_start, err}), 512'd0);
        chk("rst_data", 512'({out_data, blk_data}), 512'd0);
        repeat (2) @(negedge clk);
        chk("rst_ctl_clk", 512'({in_ready, out_valid, core_rst, sha_start, err}), 512'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_ready", 512'(in_ready), 512'd1);
        @(posedge clk); #1;

        // "abc" with latency checks
        run_msg("abc", abc, ABC_DIGEST, 1'b0);
        chk("abc_blk_lit", blk_data, {32'h61626380, 416'h0, 64'h18});
        chk("lat_crst", 512'(t_crst - t_last), 512'd2);
        chk("lat_start", 512'(t_start - t_last), 512'd3);
        chk("lat_out", 512'(t_ov - t_hd), 512'd1);

        // backpressure at byte 3
        @(posedge clk); #1;
        run_msg("bp", abc, ABC_DIGEST, 1'b1);

        // 55 bytes of 0x41
        m.delete();
        for (int i = 0; i < 55; i++) m.push_back(8'h41);
        @(posedge clk); #1;
        run_msg("max55", m, rand_sig(), 1'b0);
        chk("max55_pad", 512'(blk_data[64 +: 8]), 512'h80);
        chk("max55_len", 512'(blk_data[63:0]), 512'h1B8);

        // 56 bytes -> overflow error
        m.delete();
        for (int i = 0; i < 56; i++) m.push_back(8'($urandom()));
        clear_mon();
        @(posedge clk); #1;
        send_msg(m);
        repeat (6) @(negedge clk);
        chk("ovf_err", 512'(err_cnt), 512'd1);
        chk("ovf_start", 512'(sha_rise), 512'd0);
        chk("ovf_crst", 512'(crst_cnt), 512'd0);
        chk("ovf_outv", 512'(ov_cnt), 512'd0);
        @(posedge clk); #1;
        run_msg("post_ovf", abc, ABC_DIGEST, 1'b0);

        // random lengths and contents
        for (int n = 0; n < 5; n++) begin
            m.delete();
            for (int i = 0; i < $urandom_range(1, 55); i++) m.push_back(8'($urandom()));
            @(posedge clk); #1;
            run_msg($sformatf("rnd%0d", n), m, rand_sig(), 1'($urandom_range(0, 1)));
        end

        // core never answers -> timeout
        stub_en = 1'b0;
        clear_mon();
        @(posedge clk); #1;
        send_msg(abc);
        w = 0;
        while (err_cnt == 0 && w < 1500) begin @(negedge clk); w++; end
        chk("to_cycles", 512'(t_err - t_start), 512'(TIMEOUT));
        @(negedge clk);
        chk("to_ready", 512'(in_ready), 512'd1);
        repeat (3) @(negedge clk);
        chk("to_err_once", 512'(err_cnt), 512'd1);
        chk("to_outv", 512'(ov_cnt), 512'd0);
        stub_en = 1'b1;

        // reset in the middle of SEND
        out_ready = 1'b0;
        stub_sig  = ABC_DIGEST;
        clear_mon();
        @(posedge clk); #1;
        send_msg(abc);
        w = 0;
        while (!out_valid && w < 200) begin @(negedge clk); w++; end
        chk("mid_sending", 512'(out_valid), 512'd1);
        @(posedge clk); #2;
        rst = 1'b0;
        #1;
        chk("mid_rst_ctl", 512'({in_ready, out_valid, out_last, core_rst, sha_start, err}), 512'd0);
        chk("mid_rst_data", 512'({out_data, blk_data}), 512'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        run_msg("post_rst", abc, ABC_DIGEST, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
